// File: rtl/alu_pkg.sv
// Shared definitions for the 16-bit ALU datapath: function-select encodings,
// status bit positions and default widths.
package alu_pkg;

   localparam int N_DEF  = 16;
   localparam int RW_DEF = 3;
   localparam int FS_W   = 5;
   localparam int ST_W   = 4;

   typedef enum logic [FS_W-1:0] {
      FS_CLR  = 5'd0,
      FS_ADD  = 5'd1,
      FS_SUB  = 5'd2,
      FS_DEC  = 5'd3,
      FS_NEG  = 5'd4,
      FS_XOR  = 5'd5,
      FS_ADDC = 5'd6,
      FS_INC  = 5'd7,
      FS_SET  = 5'd8,
      FS_NOT  = 5'd9,
      FS_AND  = 5'd10,
      FS_OR   = 5'd11,
      FS_MOVA = 5'd12,
      FS_SHR  = 5'd13,
      FS_SHL  = 5'd14,
      FS_ASHR = 5'd15,
      FS_MOVB = 5'd16
   } fs_e;

   // Bit positions inside the {V,C,N,Z} status word
   localparam int ST_V = 3;
   localparam int ST_C = 2;
   localparam int ST_N = 1;
   localparam int ST_Z = 0;

endpackage

// File: rtl/alu_stage_reg.sv
// Pipeline stage register: payload with its own load enable plus a valid bit
// that can be set or cleared independently of the payload.
module alu_stage_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         valid_we,
   input  logic         valid_d,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   logic [W-1:0] q_reg;
   logic         valid_reg;

   // Payload holds when not loaded so downstream sees stable values while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_reg <= '0;
      end else if (load) begin
         q_reg <= d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_reg <= 1'b0;
      end else if (valid_we) begin
         valid_reg <= valid_d;
      end
   end

   assign q     = q_reg;
   assign valid = valid_reg;

endmodule

// File: rtl/alu_issue_stage.sv
// Execute/writeback register pair around the external combinational ALU, with
// stored carry, status flags, RAW hazard stall and writeback-stage forwarding.
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int RW = RW_DEF
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N-1:0]    in_a,
   input  logic [N-1:0]    in_b,
   input  logic [RW-1:0]   in_ra,
   input  logic [RW-1:0]   in_rb,
   input  logic [FS_W-1:0] in_fs,
   input  logic [RW-1:0]   in_rd,
   input  logic            in_wr_en,
   input  logic            in_flag_en,
   output logic [N-1:0]    alu_a,
   output logic [N-1:0]    alu_b,
   output logic [FS_W-1:0] alu_fs,
   output logic            alu_cin,
   input  logic [N-1:0]    alu_fout,
   input  logic [ST_W-1:0] alu_status,
   input  logic            alu_cout,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N-1:0]    out_data,
   output logic [RW-1:0]   out_rd,
   output logic            out_wr_en,
   output logic            carry_flag,
   output logic [ST_W-1:0] status_flags
);

   localparam int S1_W = 2*N + FS_W + RW + 2;
   localparam int S2_W = N + RW + 1;

   // Execute stage fields
   logic [S1_W-1:0] s1_d, s1_q;
   logic            s1_valid;
   logic [N-1:0]    s1_a, s1_b;
   logic [FS_W-1:0] s1_fs;
   logic [RW-1:0]   s1_rd;
   logic            s1_wr_en, s1_flag_en;

   // Writeback stage fields
   logic [S2_W-1:0] s2_d, s2_q;
   logic            s2_valid;
   logic [N-1:0]    s2_data;
   logic [RW-1:0]   s2_rd;
   logic            s2_wr_en;

   logic            s2_free, s1_adv, hazard, accept;
   logic            carry_reg;
   logic [ST_W-1:0] status_reg;

   logic [RW-1:0]   src_idx  [2];
   logic [N-1:0]    src_data [2];
   logic [N-1:0]    opnd     [2];
   logic [1:0]      src_hit;

   assign {s1_a, s1_b, s1_fs, s1_rd, s1_wr_en, s1_flag_en} = s1_q;
   assign {s2_data, s2_rd, s2_wr_en} = s2_q;

   assign src_idx[0]  = in_ra;
   assign src_idx[1]  = in_rb;
   assign src_data[0] = in_a;
   assign src_data[1] = in_b;

   // Per source: take the writeback result when it targets that register
   // (still valid when it retires on the same edge); also flag a conflict
   // with the producer still in execute, which must stall instead.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_src
         assign opnd[gi]    = (s2_valid && s2_wr_en && (src_idx[gi] == s2_rd))
                              ? s2_data : src_data[gi];
         assign src_hit[gi] = (src_idx[gi] == s1_rd);
      end
   endgenerate

   assign s2_free  = ~s2_valid | out_ready;
   assign s1_adv   = s1_valid & s2_free;
   assign hazard   = s1_valid & s1_wr_en & (|src_hit);
   assign in_ready = (~s1_valid | s1_adv) & ~hazard;
   assign accept   = in_valid & in_ready;

   assign s1_d = {opnd[0], opnd[1], in_fs, in_rd, in_wr_en, in_flag_en};
   assign s2_d = {alu_fout, s1_rd, s1_wr_en};

   alu_stage_reg #(.W(S1_W)) u_s1 (
      .clk      (clk),
      .reset    (reset),
      .load     (accept),
      .valid_we (accept | s1_adv),
      .valid_d  (accept),
      .d        (s1_d),
      .q        (s1_q),
      .valid    (s1_valid)
   );

   alu_stage_reg #(.W(S2_W)) u_s2 (
      .clk      (clk),
      .reset    (reset),
      .load     (s1_adv),
      .valid_we (s1_adv | out_ready),
      .valid_d  (s1_adv),
      .d        (s2_d),
      .q        (s2_q),
      .valid    (s2_valid)
   );

   // Flags commit as the op leaves execute, so a following ADDC entering on
   // the same edge already sees the new carry.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         carry_reg  <= 1'b0;
         status_reg <= '0;
      end else if (s1_adv && s1_flag_en) begin
         carry_reg  <= alu_cout;
         status_reg <= alu_status;
      end
   end

   assign alu_a        = s1_a;
   assign alu_b        = s1_b;
   assign alu_fs       = s1_fs;
   assign alu_cin      = carry_reg;
   assign out_valid    = s2_valid;
   assign out_data     = s2_data;
   assign out_rd       = s2_rd;
   assign out_wr_en    = s2_wr_en & s2_valid;
   assign carry_flag   = carry_reg;
   assign status_flags = status_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios followed by random traffic,
// checked against a program-order architectural register/flag model.
module tb_alu_issue_stage;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready;
   logic [15:0] in_a, in_b;
   logic [2:0]  in_ra, in_rb, in_rd;
   logic [4:0]  in_fs;
   logic        in_wr_en, in_flag_en;
   logic [15:0] alu_a, alu_b, alu_fout;
   logic [4:0]  alu_fs;
   logic        alu_cin, alu_cout;
   logic [3:0]  alu_status;
   logic        out_valid, out_ready;
   logic [15:0] out_data;
   logic [2:0]  out_rd;
   logic        out_wr_en, carry_flag;
   logic [3:0]  status_flags;

   int n_vec = 0;
   int n_err = 0;

   typedef struct packed {
      logic [15:0] data;
      logic [2:0]  rd;
      logic        wr;
      logic        c;
      logic [3:0]  st;
   } exp_t;

   exp_t        exp_q [$];
   logic [15:0] rf [8] = '{16'h0003, 16'h0004, 16'hFFFF, 16'h0001,
                           16'h0000, 16'h0000, 16'h0000, 16'h0000};
   logic [15:0] arch_rf [8];
   logic        arch_c;
   logic [3:0]  arch_st;
   logic        last_acc = 1'b0;
   logic [4:0]  fs_tab [10] = '{FS_ADD, FS_SUB, FS_ADDC, FS_AND, FS_OR,
                                FS_XOR, FS_MOVA, FS_MOVB, FS_INC, FS_DEC};

   alu_issue_stage #(.N(16), .RW(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_a         (in_a),
      .in_b         (in_b),
      .in_ra        (in_ra),
      .in_rb        (in_rb),
      .in_fs        (in_fs),
      .in_rd        (in_rd),
      .in_wr_en     (in_wr_en),
      .in_flag_en   (in_flag_en),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_fs       (alu_fs),
      .alu_cin      (alu_cin),
      .alu_fout     (alu_fout),
      .alu_status   (alu_status),
      .alu_cout     (alu_cout),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_rd       (out_rd),
      .out_wr_en    (out_wr_en),
      .carry_flag   (carry_flag),
      .status_flags (status_flags)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {V,C,N,Z, cout, fout}
   function automatic logic [20:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic [4:0] fs, input logic cin);
      logic [16:0] s;
      logic [15:0] bb, f;
      logic        arith, v, c;
      s = '0; bb = b; arith = 1'b1;
      case (fs)
         FS_ADD:  s = {1'b0, a} + {1'b0, b};
         FS_ADDC: s = {1'b0, a} + {1'b0, b} + {16'b0, cin};
         FS_SUB:  begin bb = ~b; s = {1'b0, a} + {1'b0, bb} + 17'd1; end
         FS_INC:  begin bb = 16'h0000; s = {1'b0, a} + 17'd1; end
         FS_DEC:  begin bb = 16'hFFFF; s = {1'b0, a} + 17'h0FFFF; end
         default: arith = 1'b0;
      endcase
      if (arith) f = s[15:0];
      else begin
         case (fs)
            FS_CLR:  f = 16'h0000;
            FS_SET:  f = 16'hFFFF;
            FS_AND:  f = a & b;
            FS_OR:   f = a | b;
            FS_XOR:  f = a ^ b;
            FS_NOT:  f = ~a;
            FS_MOVA: f = a;
            FS_MOVB: f = b;
            FS_SHL:  f = a << 1;
            FS_SHR:  f = a >> 1;
            default: f = a ^ b ^ {11'b0, fs};
         endcase
      end
      v = arith & (a[15] == bb[15]) & (f[15] != a[15]);
      c = arith & s[16];
      return {v, c, f[15], (f == 16'h0000), c, f};
   endfunction

   always_comb {alu_status, alu_cout, alu_fout} = alu_fn(alu_a, alu_b, alu_fs, alu_cin);

   // Register file fed by the writeback port supplies the decode-stage operands
   assign in_a = rf[in_ra];
   assign in_b = rf[in_rb];
   always @(posedge clk)
      if (!reset && out_valid && out_ready && out_wr_en) rf[out_rd] <= out_data;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   // Reference model: every accepted op is executed in program order on the
   // architectural state; each retirement must match the oldest expectation.
   always @(negedge clk) begin
      exp_t        e;
      logic [20:0] r;
      if (reset) begin
         exp_q.delete();
         arch_rf  = rf;
         arch_c   = 1'b0;
         arch_st  = 4'h0;
         last_acc = 1'b0;
      end else begin
         last_acc = in_valid && in_ready;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out", {31'b0, out_valid}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               $display("retire rd=%0d data=%h c=%b st=%h", out_rd, out_data, carry_flag, status_flags);
               check_eq("out_data", {16'b0, out_data}, {16'b0, e.data});
               check_eq("out_rd", {29'b0, out_rd}, {29'b0, e.rd});
               check_eq("out_wr_en", {31'b0, out_wr_en}, {31'b0, e.wr});
               check_eq("carry_flag", {31'b0, carry_flag}, {31'b0, e.c});
               check_eq("status_flags", {28'b0, status_flags}, {28'b0, e.st});
            end
         end
         if (in_valid && in_ready) begin
            r = alu_fn(arch_rf[in_ra], arch_rf[in_rb], in_fs, arch_c);
            if (in_flag_en) begin
               arch_c  = r[16];
               arch_st = r[20:17];
            end
            if (in_wr_en) arch_rf[in_rd] = r[15:0];
            e = '{data: r[15:0], rd: in_rd, wr: in_wr_en, c: arch_c, st: arch_st};
            exp_q.push_back(e);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [2:0] ra, input logic [2:0] rb, input logic [4:0] fs,
                        input logic [2:0] rd, input logic wr, input logic fl);
      in_valid = 1'b1; in_ra = ra; in_rb = rb; in_fs = fs;
      in_rd = rd; in_wr_en = wr; in_flag_en = fl;
   endtask

   initial begin
      reset = 1'b1; out_ready = 1'b0;
      in_valid = 1'b0; in_ra = '0; in_rb = '0; in_fs = '0;
      in_rd = '0; in_wr_en = 1'b0; in_flag_en = 1'b0;

      // Reset state
      @(negedge clk);
      check_eq("rst_out_valid", {31'b0, out_valid}, 32'd0);
      check_eq("rst_carry", {31'b0, carry_flag}, 32'd0);
      check_eq("rst_status", {28'b0, status_flags}, 32'd0);
      check_eq("rst_out_data", {16'b0, out_data}, 32'd0);
      check_eq("rst_alu_a", {16'b0, alu_a}, 32'd0);
      check_eq("rst_alu_fs", {27'b0, alu_fs}, 32'd0);
      tick();
      reset = 1'b0; out_ready = 1'b1;

      // Single ADD: r0(3) + r1(4) -> r5, visible in cycle k+2
      tick();
      drive(3'd0, 3'd1, FS_ADD, 3'd5, 1'b1, 1'b0);
      @(negedge clk); check_eq("single_ready", {31'b0, in_ready}, 32'd1);
      tick(); in_valid = 1'b0;
      @(negedge clk); check_eq("single_k1_valid", {31'b0, out_valid}, 32'd0);
      tick();
      @(negedge clk);
      check_eq("single_k2_valid", {31'b0, out_valid}, 32'd1);
      check_eq("single_data", {16'b0, out_data}, 32'h0007);
      check_eq("single_rd", {29'b0, out_rd}, 32'd5);

      // Carry chain: ADD FFFF+0001 then ADDC 0+0 back-to-back
      tick();
      drive(3'd2, 3'd3, FS_ADD, 3'd6, 1'b1, 1'b1);
      @(negedge clk); check_eq("chain_ready1", {31'b0, in_ready}, 32'd1);
      tick();
      drive(3'd4, 3'd4, FS_ADDC, 3'd7, 1'b1, 1'b1);
      @(negedge clk); check_eq("chain_nostall", {31'b0, in_ready}, 32'd1);
      tick(); in_valid = 1'b0;
      @(negedge clk);
      check_eq("chain_data1", {16'b0, out_data}, 32'h0000);
      check_eq("chain_carry1", {31'b0, carry_flag}, 32'd1);
      check_eq("chain_cin", {31'b0, alu_cin}, 32'd1);
      tick();
      @(negedge clk); check_eq("chain_data2", {16'b0, out_data}, 32'h0001);

      // Backpressure: three ops offered while the consumer stalls
      tick(); out_ready = 1'b0;
      drive(3'd0, 3'd1, FS_ADD, 3'd4, 1'b1, 1'b0);
      @(negedge clk); check_eq("bp_acc_a", {31'b0, in_ready}, 32'd1);
      tick();
      drive(3'd0, 3'd1, FS_AND, 3'd5, 1'b1, 1'b0);
      @(negedge clk); check_eq("bp_acc_b", {31'b0, in_ready}, 32'd1);
      tick();
      drive(3'd0, 3'd1, FS_OR, 3'd6, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("bp_stall_ready", {31'b0, in_ready}, 32'd0);
         check_eq("bp_hold_data", {16'b0, out_data}, 32'h0007);
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      check_eq("bp_acc_c", {31'b0, in_ready}, 32'd1);
      check_eq("bp_out_a", {16'b0, out_data}, 32'h0007);
      tick(); in_valid = 1'b0;
      @(negedge clk);
      check_eq("bp_valid_b", {31'b0, out_valid}, 32'd1);
      check_eq("bp_out_b", {16'b0, out_data}, 32'h0000);
      tick();
      @(negedge clk);
      check_eq("bp_valid_c", {31'b0, out_valid}, 32'd1);
      check_eq("bp_out_c", {16'b0, out_data}, 32'h0007);
      tick();
      @(negedge clk); check_eq("bp_drained", {31'b0, out_valid}, 32'd0);

      // RAW: r1 = r0+r1 (7), then r2 = r1+r0 must see 7 via forwarding
      tick();
      drive(3'd0, 3'd1, FS_ADD, 3'd1, 1'b1, 1'b0);
      @(negedge clk); check_eq("raw_acc1", {31'b0, in_ready}, 32'd1);
      tick();
      drive(3'd1, 3'd0, FS_ADD, 3'd2, 1'b1, 1'b0);
      @(negedge clk); check_eq("raw_stall", {31'b0, in_ready}, 32'd0);
      tick();
      @(negedge clk);
      check_eq("raw_release", {31'b0, in_ready}, 32'd1);
      check_eq("raw_prod", {16'b0, out_data}, 32'h0007);
      tick(); in_valid = 1'b0;
      tick();
      @(negedge clk);
      check_eq("raw_fwd_data", {16'b0, out_data}, 32'h000A);
      check_eq("raw_fwd_rd", {29'b0, out_rd}, 32'd2);

      // Reset with both stages full: r0(3) - r1(7) sets N before reset
      tick(); out_ready = 1'b0;
      drive(3'd0, 3'd1, FS_SUB, 3'd4, 1'b1, 1'b1);
      tick();
      drive(3'd0, 3'd0, FS_MOVA, 3'd5, 1'b1, 1'b0);
      tick(); in_valid = 1'b0;
      @(negedge clk);
      check_eq("prerst_valid", {31'b0, out_valid}, 32'd1);
      check_eq("prerst_status", {28'b0, status_flags}, 32'h2);
      #2 reset = 1'b1;
      #1;
      check_eq("midrst_valid", {31'b0, out_valid}, 32'd0);
      check_eq("midrst_carry", {31'b0, carry_flag}, 32'd0);
      check_eq("midrst_status", {28'b0, status_flags}, 32'd0);
      @(negedge clk);
      tick(); reset = 1'b0; out_ready = 1'b1;
      @(negedge clk);
      check_eq("postrst_ready", {31'b0, in_ready}, 32'd1);
      check_eq("postrst_valid", {31'b0, out_valid}, 32'd0);
      tick();
      drive(3'd0, 3'd0, FS_ADD, 3'd3, 1'b1, 1'b0);
      tick(); in_valid = 1'b0;
      tick();
      @(negedge clk);
      check_eq("postrst_valid2", {31'b0, out_valid}, 32'd1);
      check_eq("postrst_data", {16'b0, out_data}, 32'h0006);

      // Random traffic against the architectural model
      for (int cyc = 0; cyc < 600; cyc++) begin
         tick();
         if (!in_valid || last_acc) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_ra      = 3'($urandom_range(0, 7));
            in_rb      = 3'($urandom_range(0, 7));
            in_rd      = 3'($urandom_range(0, 7));
            in_wr_en   = ($urandom_range(0, 4) != 0);
            in_flag_en = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 9) == 0) in_fs = 5'($urandom_range(17, 31));
            else in_fs = fs_tab[$urandom_range(0, 9)];
         end
         out_ready = ($urandom_range(0, 3) != 0);
      end
      tick(); in_valid = 1'b0; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();
      check_eq("drain_empty", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
